// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch stage in front of a combinational
// Instruction_Memory. It owns the PC, captures the returned word into a
// fetch/decode register with a valid/ready handshake, and accepts
// jump/branch redirects. It also provides IDLE/RUN/HALTED control.
// Optional macro IF_PERF_COUNT_EN adds the Fetch_Count and Stall_Count
// saturating counters.
module instruction_fetch_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Start,
    input  logic                  Stop,
    output logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] Instruction,
    input  logic                  Redirect_Valid,
    input  logic [ADDR_WIDTH-1:0] Redirect_Target,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic [DATA_WIDTH-1:0] Out_Instruction,
    output logic [ADDR_WIDTH-1:0] Out_PC,
    output logic                  Running
`ifdef IF_PERF_COUNT_EN
    ,
    output logic [31:0]           Fetch_Count,
    output logic [31:0]           Stall_Count
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [4:0] OPC_HALT  = 5'b11111;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_instr;
    logic [ADDR_WIDTH-1:0] r_out_pc;
    logic                  w_cap;
    logic                  w_is_halt;
    logic                  w_consume;

    // A redirect always kills the capture for that cycle because the word
    // on Instruction belongs to the discarded path.
    assign w_cap     = (r_state == ST_RUN) && (!r_out_valid || Out_Ready) && !Redirect_Valid;
    assign w_is_halt = (Instruction[DATA_WIDTH-1 -: 5] == OPC_HALT);
    assign w_consume = r_out_valid && Out_Ready;

    assign Address         = r_pc;
    assign Out_Valid       = r_out_valid;
    assign Out_Instruction = r_out_instr;
    assign Out_PC          = r_out_pc;
    assign Running         = (r_state == ST_RUN);

    // Next control state: redirect wins and only revives HALTED, then Stop
    // beats Start, and a captured HALT parks the fetcher.
    always_comb begin
        w_state_nxt = r_state;
        if (Redirect_Valid) begin
            if (r_state == ST_HALTED)
                w_state_nxt = ST_RUN;
        end else if (Stop) begin
            w_state_nxt = ST_IDLE;
        end else if (Start && (r_state != ST_RUN)) begin
            w_state_nxt = ST_RUN;
        end else if (w_cap && w_is_halt) begin
            w_state_nxt = ST_HALTED;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Program counter: a redirect loads the target, and a capture advances
    // the PC (natural wrap at 2^ADDR_WIDTH). Otherwise it holds, which
    // covers stall, IDLE and HALTED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pc <= ADDR_WIDTH'(RESET_PC);
        else if (Redirect_Valid)
            r_pc <= Redirect_Target;
        else if (w_cap)
            r_pc <= r_pc + 1'b1;
    end

    // Fetch/decode register valid bit: flush on redirect, set on capture,
    // clear when decode drains it and nothing replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_out_valid <= 1'b0;
        else if (Redirect_Valid)
            r_out_valid <= 1'b0;
        else if (w_cap)
            r_out_valid <= 1'b1;
        else if (w_consume)
            r_out_valid <= 1'b0;
    end

    // Fetch/decode register payload: written only on capture, so it holds
    // through stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_instr <= '0;
            r_out_pc    <= '0;
        end else if (w_cap) begin
            r_out_instr <= Instruction;
            r_out_pc    <= r_pc;
        end
    end

`ifdef IF_PERF_COUNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    // A stall is counted only while fetching is active and decode is
    // refusing a held entry.
    assign w_stall = (r_state == ST_RUN) && r_out_valid && !Out_Ready;

    // Saturating capture counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_fetch_cnt <= '0;
        else if (w_cap && (r_fetch_cnt != 32'hFFFF_FFFF))
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end

    // Saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign Fetch_Count = r_fetch_cnt;
    assign Stall_Count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios with literal
// expectations, plus a stream model that checks every delivered word.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Start, Stop;
    logic [7:0]  Address;
    logic [31:0] Instruction;
    logic        Redirect_Valid;
    logic [7:0]  Redirect_Target;
    logic        Out_Valid, Out_Ready;
    logic [31:0] Out_Instruction;
    logic [7:0]  Out_PC;
    logic        Running;
`ifdef IF_PERF_COUNT_EN
    logic [31:0] Fetch_Count, Stall_Count;
`endif

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mem [0:255];
    logic [7:0]  m_expect;
    logic [7:0]  m_nx;

    always #5 clk = ~clk;

    assign Instruction = mem[Address];

    instruction_fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Stop(Stop),
        .Address(Address), .Instruction(Instruction),
        .Redirect_Valid(Redirect_Valid), .Redirect_Target(Redirect_Target),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Out_Instruction(Out_Instruction), .Out_PC(Out_PC), .Running(Running)
`ifdef IF_PERF_COUNT_EN
        , .Fetch_Count(Fetch_Count), .Stall_Count(Stall_Count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(Out_Valid), 32'd0);
        chk({tag, "_instr"}, Out_Instruction, 32'd0);
        chk({tag, "_pc"},    32'(Out_PC), 32'd0);
        chk({tag, "_run"},   32'(Running), 32'd0);
        chk({tag, "_addr"},  32'(Address), 32'd0);
    endtask

    // Stream model. Decode must receive consecutive addresses, restarting at
    // each redirect target. A held word always matches memory at its PC. The
    // PC points one past the held word, or at the next expected word when
    // the register is empty.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_expect = 8'd0;
        end else begin
            if (Out_Valid) begin
                m_nx = Out_PC + 8'd1;
                chk("model_addr_after_held", 32'(Address), 32'(m_nx));
                chk("model_held_word", Out_Instruction, mem[Out_PC]);
            end else begin
                chk("model_addr_empty", 32'(Address), 32'(m_expect));
            end
            if (Out_Valid && Out_Ready) begin
                chk("model_stream_pc", 32'(Out_PC), 32'(m_expect));
                m_expect = Out_PC + 8'd1;
            end
            if (Redirect_Valid)
                m_expect = Redirect_Target;
        end
    end

    initial begin
        // Every word is {opcode, 3'b0, 8'hA5, 8'h3C, addr}. The opcode is
        // addr % 25, which keeps it inside 0..24, except word 40 is a HALT.
        for (int i = 0; i < 256; i++)
            mem[i] = {5'(i % 25), 3'b000, 8'hA5, 8'h3C, 8'(i)};
        mem[40] = {5'b11111, 3'b000, 8'hA5, 8'h3C, 8'd40};

        rst_n = 1'b0; Start = 0; Stop = 0; Redirect_Valid = 0;
        Redirect_Target = 8'd0; Out_Ready = 0;
        #2;
        chk_reset_vals("reset");
        #1 rst_n = 1'b1;
        tick();
        chk("idle_run", 32'(Running), 32'd0);
        chk("idle_valid", 32'(Out_Valid), 32'd0);

        // 1: sequential fetch
        Out_Ready = 1; Start = 1;
        tick(); Start = 0;
        chk("start_run", 32'(Running), 32'd1);
        chk("start_nocap", 32'(Out_Valid), 32'd0);
        chk("start_addr", 32'(Address), 32'd0);
        tick();
        chk("first_valid", 32'(Out_Valid), 32'd1);
        chk("first_pc", 32'(Out_PC), 32'd0);
        chk("first_addr", 32'(Address), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("seq_pc", 32'(Out_PC), 32'(i));
        end
        chk("seq_word4", Out_Instruction, 32'h20A53C04);

        // 2: three stall cycles at Out_PC=4
        Out_Ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", 32'(Out_PC), 32'd4);
            chk("stall_addr", 32'(Address), 32'd5);
            chk("stall_instr", Out_Instruction, 32'h20A53C04);
            chk("stall_valid", 32'(Out_Valid), 32'd1);
        end
        Out_Ready = 1;
        tick();
        chk("unstall_pc", 32'(Out_PC), 32'd5);
`ifdef IF_PERF_COUNT_EN
        chk("perf_stall", Stall_Count, 32'd3);
        chk("perf_fetch", Fetch_Count, 32'd6);
`endif

        // 3: redirect while stalled
        Out_Ready = 0; Redirect_Valid = 1; Redirect_Target = 8'd35;
        tick(); Redirect_Valid = 0;
        chk("redir_flush", 32'(Out_Valid), 32'd0);
        chk("redir_addr", 32'(Address), 32'd35);
        tick();
        chk("redir_valid", 32'(Out_Valid), 32'd1);
        chk("redir_pc", 32'(Out_PC), 32'd35);
        Out_Ready = 1;

        // 4: HALT at word 40
        repeat (5) tick();
        chk("halt_pc", 32'(Out_PC), 32'd40);
        chk("halt_word", Out_Instruction, 32'hF8A53C28);
        chk("halt_valid", 32'(Out_Valid), 32'd1);
        chk("halt_run", 32'(Running), 32'd0);
        chk("halt_addr", 32'(Address), 32'd41);
        tick();
        chk("halt_drained", 32'(Out_Valid), 32'd0);
        tick();
        chk("halt_hold_addr", 32'(Address), 32'd41);
        chk("halt_hold_valid", 32'(Out_Valid), 32'd0);
        Start = 1;
        tick(); Start = 0;
        chk("resume_run", 32'(Running), 32'd1);
        tick();
        chk("resume_pc", 32'(Out_PC), 32'd41);
        chk("resume_word", Out_Instruction, 32'h80A53C29);

        // 5: stop, redirect to 254 while idle, wrap, async reset
        Stop = 1; Start = 1;
        tick(); Stop = 0; Start = 0;
        chk("stop_run", 32'(Running), 32'd0);
        chk("stop_held_pc", 32'(Out_PC), 32'd42);
        tick();
        chk("stop_drained", 32'(Out_Valid), 32'd0);
        chk("stop_addr", 32'(Address), 32'd43);
        Redirect_Valid = 1; Redirect_Target = 8'd254;
        tick(); Redirect_Valid = 0;
        chk("idle_redir_addr", 32'(Address), 32'd254);
        chk("idle_redir_run", 32'(Running), 32'd0);
        Start = 1;
        tick(); Start = 0;
        tick(); chk("wrap_pc0", 32'(Out_PC), 32'd254);
        tick(); chk("wrap_pc1", 32'(Out_PC), 32'd255);
        tick(); chk("wrap_pc2", 32'(Out_PC), 32'd0);
        tick(); chk("wrap_pc3", 32'(Out_PC), 32'd1);
        chk("wrap_addr", 32'(Address), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        #2 rst_n = 1'b1;
        tick();
        chk("post_reset_valid", 32'(Out_Valid), 32'd0);
        chk("post_reset_addr", 32'(Address), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
